// File: rtl/shot_responder.sv
// rtl/shot_responder.sv - own-board shot responder: ship placement, shot lookup, response handshake
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   armed             0 = placement phase, 1 = battle phase
//   board_clr         one-cycle pulse that wipes the board and counters
//   place_valid/addr  mark one own ship cell ([7:4] row, [3:0] col)
//   shot_valid/addr   opponent shot; accepted when shot_ready is also high
//   shot_ready        shot accepted this cycle if shot_valid is high
//   msg_valid/out     response: 01 miss, 10 hit, 11 fleet destroyed; held until msg_ack
//   msg_ack           consumer has taken the response
//   cells_placed      ship cells marked (saturates at 15)
//   cells_left        ship cells not yet hit

module shot_responder (
    input  logic       clk,
    input  logic       rst,
    input  logic       armed,
    input  logic       board_clr,
    input  logic       place_valid,
    input  logic [7:0] place_addr,
    input  logic       shot_valid,
    input  logic [7:0] shot_addr,
    output logic       shot_ready,
    output logic       msg_valid,
    output logic [1:0] msg_out,
    input  logic       msg_ack,
    output logic [3:0] cells_placed,
    output logic [3:0] cells_left
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, DONE} state_t;

    localparam logic [1:0] MSG_NONE = 2'b00;
    localparam logic [1:0] MSG_MISS = 2'b01;
    localparam logic [1:0] MSG_HIT  = 2'b10;
    localparam logic [1:0] MSG_SUNK = 2'b11;

    state_t      state;
    logic [99:0] ship_map;
    logic [99:0] hit_map;
    logic [7:0]  shot_q;

    function automatic logic on_board(input logic [7:0] a);
        return (a[7:4] <= 4'd9) && (a[3:0] <= 4'd9);
    endfunction

    function automatic logic [6:0] cell_idx(input logic [7:0] a);
        return {3'b000, a[7:4]} * 7'd10 + {3'b000, a[3:0]};
    endfunction

    logic [6:0] place_idx;
    logic [6:0] shot_idx;
    logic       place_ok;
    logic       fresh_hit;
    logic       shot_take;

    assign place_idx = cell_idx(place_addr);
    assign shot_idx  = cell_idx(shot_q);

    // Off-board addresses are filtered before the map bit is used, so an
    // out-of-range index never influences the decision.
    assign place_ok  = on_board(place_addr) && !ship_map[place_idx] && (cells_placed != 4'd15);
    assign fresh_hit = on_board(shot_q) && ship_map[shot_idx] && !hit_map[shot_idx];

    // Ready is withheld while reset or a board clear is pending so that a
    // shot is never reported as taken in a cycle that discards it.
    assign shot_ready = !rst && !board_clr &&
                        (((state == IDLE) && armed) || (state == DONE));
    assign shot_take  = shot_valid && shot_ready;

    always_ff @(posedge clk) begin
        if (rst || board_clr) begin
            state        <= IDLE;
            ship_map     <= '0;
            hit_map      <= '0;
            shot_q       <= '0;
            cells_placed <= '0;
            cells_left   <= '0;
            msg_valid    <= 1'b0;
            msg_out      <= MSG_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (shot_take) begin
                        shot_q <= shot_addr;
                        state  <= LOOKUP;
                    end else if (!armed && place_valid && place_ok) begin
                        ship_map[place_idx] <= 1'b1;
                        cells_placed        <= cells_placed + 4'd1;
                        cells_left          <= cells_left + 4'd1;
                    end
                end
                LOOKUP: begin
                    state     <= RESPOND;
                    msg_valid <= 1'b1;
                    // A fresh hit implies an unhit ship cell, so cells_left >= 1 here.
                    if (fresh_hit) begin
                        hit_map[shot_idx] <= 1'b1;
                        cells_left        <= cells_left - 4'd1;
                        msg_out           <= (cells_left == 4'd1) ? MSG_SUNK : MSG_HIT;
                    end else begin
                        msg_out <= MSG_MISS;
                    end
                end
                RESPOND: begin
                    if (msg_ack) begin
                        msg_valid <= 1'b0;
                        msg_out   <= MSG_NONE;
                        state     <= ((cells_left == 4'd0) && (cells_placed != 4'd0)) ? DONE : IDLE;
                    end
                end
                DONE: begin
                    // Fleet is gone: every further shot is answered without a lookup.
                    if (shot_take) begin
                        msg_valid <= 1'b1;
                        msg_out   <= MSG_SUNK;
                        state     <= RESPOND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_responder.sv
// tb/tb_shot_responder.sv - self-checking scoreboard bench for shot_responder

module tb_shot_responder;

    logic       clk;
    logic       rst;
    logic       armed;
    logic       board_clr;
    logic       place_valid;
    logic [7:0] place_addr;
    logic       shot_valid;
    logic [7:0] shot_addr;
    logic       shot_ready;
    logic       msg_valid;
    logic [1:0] msg_out;
    logic       msg_ack;
    logic [3:0] cells_placed;
    logic [3:0] cells_left;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];

    shot_responder dut (
        .clk          (clk),
        .rst          (rst),
        .armed        (armed),
        .board_clr    (board_clr),
        .place_valid  (place_valid),
        .place_addr   (place_addr),
        .shot_valid   (shot_valid),
        .shot_addr    (shot_addr),
        .shot_ready   (shot_ready),
        .msg_valid    (msg_valid),
        .msg_out      (msg_out),
        .msg_ack      (msg_ack),
        .cells_placed (cells_placed),
        .cells_left   (cells_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input logic [7:0] a);
        place_valid = 1'b1;
        place_addr  = a;
        tick();
        place_valid = 1'b0;
    endtask

    // Present one shot, push its expected response, then check latency,
    // hold-until-ack behaviour and the popped scoreboard entry.
    task automatic shoot(input string tag, input logic [7:0] a, input logic [1:0] exp, input bit from_done);
        int n;
        logic [1:0] e;
        n = 0;
        while (!shot_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, shot_ready, 1);
        shot_valid = 1'b1;
        shot_addr  = a;
        exp_q.push_back(exp);
        tick();
        shot_valid = 1'b0;
        if (!from_done) begin
            chk({tag, "_lookup_novalid"}, msg_valid, 0);
            tick();
        end
        chk({tag, "_valid"}, msg_valid, 1);
        chk({tag, "_ready_low"}, shot_ready, 0);
        repeat (2) tick();
        chk({tag, "_held"}, msg_valid, 1);
        e = exp_q.pop_front();
        chk({tag, "_msg"}, msg_out, e);
        msg_ack = 1'b1;
        tick();
        msg_ack = 1'b0;
        chk({tag, "_drop_valid"}, msg_valid, 0);
        chk({tag, "_drop_msg"}, msg_out, 0);
    endtask

    initial begin
        rst = 1'b1; armed = 1'b1; board_clr = 1'b0;
        place_valid = 1'b0; place_addr = '0;
        shot_valid = 1'b0; shot_addr = '0; msg_ack = 1'b0;
        repeat (2) tick();
        chk("rst_ready", shot_ready, 0);
        chk("rst_valid", msg_valid, 0);
        chk("rst_msg", msg_out, 0);
        chk("rst_placed", cells_placed, 0);
        chk("rst_left", cells_left, 0);
        rst = 1'b0; armed = 1'b0;
        tick();
        chk("idle_unarmed_ready", shot_ready, 0);

        // Placement: duplicate and off-board (row and col) ignored
        place(8'h00); place(8'h01); place(8'h01); place(8'hA3); place(8'h3A);
        chk("place_count", cells_placed, 2);
        chk("place_left", cells_left, 2);

        // Battle phase; placement now ignored
        armed = 1'b1;
        tick();
        place(8'h22);
        chk("armed_place_ignored", cells_placed, 2);

        shoot("miss55", 8'h55, 2'b01, 1'b0);
        shoot("hit00", 8'h00, 2'b10, 1'b0);
        chk("hit00_left", cells_left, 1);
        shoot("rep00", 8'h00, 2'b01, 1'b0);
        chk("rep00_left", cells_left, 1);
        shoot("offboard", 8'hFF, 2'b01, 1'b0);
        shoot("sink01", 8'h01, 2'b11, 1'b0);
        chk("sink_left", cells_left, 0);
        chk("sink_placed", cells_placed, 2);
        armed = 1'b0;
        #1;
        chk("done_ready_unarmed", shot_ready, 1);
        shoot("done99", 8'h99, 2'b11, 1'b1);

        // Reset mid-RESPOND with ack held low abandons the response
        shot_valid = 1'b1; shot_addr = 8'h44;
        exp_q.push_back(2'b11);
        tick();
        shot_valid = 1'b0;
        chk("pre_rst_valid", msg_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_front());
        chk("rst_mid_valid", msg_valid, 0);
        chk("rst_mid_placed", cells_placed, 0);
        chk("rst_mid_left", cells_left, 0);
        repeat (3) tick();
        chk("rst_no_stale_valid", msg_valid, 0);

        // Rebuild a one-cell fleet, sink it, then board_clr in DONE
        place(8'h12);
        chk("reb_placed", cells_placed, 1);
        armed = 1'b1;
        shoot("sink12", 8'h12, 2'b11, 1'b0);
        armed = 1'b0;
        #1;
        chk("reb_done", shot_ready, 1);
        board_clr = 1'b1;
        tick();
        board_clr = 1'b0;
        chk("clr_placed", cells_placed, 0);
        chk("clr_left", cells_left, 0);
        chk("clr_idle", shot_ready, 0);

        // Empty fleet: every shot is a miss and the FSM returns to IDLE
        armed = 1'b1;
        tick();
        shoot("empty00", 8'h00, 2'b01, 1'b0);
        armed = 1'b0;
        #1;
        chk("empty_idle", shot_ready, 0);
        chk("empty_left", cells_left, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
